// File: rtl/lane_chain_adder_fu.sv
// Segmented multi-lane adder/subtractor. The carry ripples one lane per pipeline stage,
// so every segmentation mode has the same latency and one transaction can enter per cycle.
module lane_chain_adder_fu #(
    parameter int WIDTH = 16,
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    input  logic [1:0]             cfg_seg,
    input  logic                   cfg_sub,
    input  logic [3:0]             cfg_dest,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_sum,
    output logic [LANES-1:0]       out_carry,
    output logic [LANES-1:0]       out_ovf,
    output logic [3:0]             out_dest
);

    localparam int VW = LANES * WIDTH;
    localparam int LOG2 = (LANES > 1) ? $clog2(LANES) : 0;
    localparam logic [2:0] LOG2_W = 3'(LOG2);

    logic en_s;

    // Stage-input bundles: index j feeds the stage that computes lane j.
    logic             st_valid_s [LANES];
    logic [VW-1:0]    st_a_s     [LANES];
    logic [VW-1:0]    st_b_s     [LANES];
    logic [VW-1:0]    st_sum_s   [LANES];
    logic             st_carry_s [LANES];
    logic [LANES-1:0] st_cvec_s  [LANES];
    logic [LANES-1:0] st_ovec_s  [LANES];
    logic [1:0]       st_seg_s   [LANES];
    logic             st_sub_s   [LANES];
    logic [3:0]       st_dest_s  [LANES];

    assign en_s     = !out_valid || out_ready;
    assign in_ready = en_s;

    assign st_valid_s[0] = in_valid;
    assign st_a_s[0]     = in_a;
    assign st_b_s[0]     = in_b;
    assign st_sum_s[0]   = {VW{1'b0}};
    assign st_carry_s[0] = 1'b0;
    assign st_cvec_s[0]  = {LANES{1'b0}};
    assign st_ovec_s[0]  = {LANES{1'b0}};
    assign st_seg_s[0]   = ({1'b0, cfg_seg} > LOG2_W) ? LOG2_W[1:0] : cfg_seg;
    assign st_sub_s[0]   = cfg_sub;
    assign st_dest_s[0]  = cfg_dest;

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        localparam logic [3:0] LANE_IDX = 4'(j);

        logic [WIDTH-1:0] op_a_s;
        logic [WIDTH-1:0] op_b_s;
        logic [WIDTH-1:0] sum_s;
        logic [3:0]       seg_mask_s;
        logic             is_lsb_s;
        logic             is_msb_s;
        logic             cin_s;
        logic             cout_s;
        logic             ovf_s;
        logic [VW-1:0]    nxt_sum_s;
        logic [LANES-1:0] nxt_cvec_s;
        logic [LANES-1:0] nxt_ovec_s;

        // One lane of the segmented chain; operands always sit in the low lane of the bundle.
        always_comb begin
            op_a_s = st_a_s[j][WIDTH-1:0];
            if (st_sub_s[j]) begin
                op_b_s = ~st_b_s[j][WIDTH-1:0];
            end else begin
                op_b_s = st_b_s[j][WIDTH-1:0];
            end
            seg_mask_s = (4'd1 << st_seg_s[j]) - 4'd1;
            is_lsb_s   = ((LANE_IDX & seg_mask_s) == 4'd0);
            is_msb_s   = (((LANE_IDX + 4'd1) & seg_mask_s) == 4'd0);
            if (is_lsb_s) begin
                cin_s = st_sub_s[j];
            end else begin
                cin_s = st_carry_s[j];
            end
            {cout_s, sum_s} = {1'b0, op_a_s} + {1'b0, op_b_s} + {{WIDTH{1'b0}}, cin_s};
            ovf_s = (op_a_s[WIDTH-1] == op_b_s[WIDTH-1]) && (sum_s[WIDTH-1] != op_a_s[WIDTH-1]);
            nxt_sum_s = st_sum_s[j];
            nxt_sum_s[j*WIDTH +: WIDTH] = sum_s;
            nxt_cvec_s = st_cvec_s[j];
            nxt_ovec_s = st_ovec_s[j];
            if (is_msb_s) begin
                nxt_cvec_s[j] = cout_s;
                nxt_ovec_s[j] = ovf_s;
            end else begin
                nxt_cvec_s[j] = 1'b0;
                nxt_ovec_s[j] = 1'b0;
            end
        end

        if (j < LANES - 1) begin : g_mid
            logic             valid_r;
            logic [VW-1:0]    a_r;
            logic [VW-1:0]    b_r;
            logic [VW-1:0]    sum_r;
            logic             carry_r;
            logic [LANES-1:0] cvec_r;
            logic [LANES-1:0] ovec_r;
            logic [1:0]       seg_r;
            logic             sub_r;
            logic [3:0]       dest_r;

            // Intermediate stage register; unconsumed operands shift down one lane.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    valid_r <= 1'b0;
                    a_r     <= {VW{1'b0}};
                    b_r     <= {VW{1'b0}};
                    sum_r   <= {VW{1'b0}};
                    carry_r <= 1'b0;
                    cvec_r  <= {LANES{1'b0}};
                    ovec_r  <= {LANES{1'b0}};
                    seg_r   <= 2'd0;
                    sub_r   <= 1'b0;
                    dest_r  <= 4'd0;
                end else if (en_s) begin
                    valid_r <= st_valid_s[j];
                    a_r     <= st_a_s[j] >> WIDTH;
                    b_r     <= st_b_s[j] >> WIDTH;
                    sum_r   <= nxt_sum_s;
                    carry_r <= cout_s;
                    cvec_r  <= nxt_cvec_s;
                    ovec_r  <= nxt_ovec_s;
                    seg_r   <= st_seg_s[j];
                    sub_r   <= st_sub_s[j];
                    dest_r  <= st_dest_s[j];
                end
            end

            assign st_valid_s[j+1] = valid_r;
            assign st_a_s[j+1]     = a_r;
            assign st_b_s[j+1]     = b_r;
            assign st_sum_s[j+1]   = sum_r;
            assign st_carry_s[j+1] = carry_r;
            assign st_cvec_s[j+1]  = cvec_r;
            assign st_ovec_s[j+1]  = ovec_r;
            assign st_seg_s[j+1]   = seg_r;
            assign st_sub_s[j+1]   = sub_r;
            assign st_dest_s[j+1]  = dest_r;
        end else begin : g_out
            // Final stage doubles as the output register and holds while stalled.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    out_valid <= 1'b0;
                    out_sum   <= {VW{1'b0}};
                    out_carry <= {LANES{1'b0}};
                    out_ovf   <= {LANES{1'b0}};
                    out_dest  <= 4'd0;
                end else if (en_s) begin
                    out_valid <= st_valid_s[j];
                    out_sum   <= nxt_sum_s;
                    out_carry <= nxt_cvec_s;
                    out_ovf   <= nxt_ovec_s;
                    out_dest  <= st_dest_s[j];
                end
            end
        end
    end

endmodule
